wb_commit_unit: RTL and testbench



---
 rtl/wb_commit_unit_if.sv | 43 ++++
 rtl/wb_commit_unit.sv | 112 +++++++++++
 tb/tb_wb_commit_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_unit_if.sv
// Retiring-instruction handshake bundle from MEM into writeback.
// The master drives the instruction; the slave answers with in_ready.
interface wb_commit_unit_if #(
   parameter int XLEN = 64,
   parameter int AW   = 5
);
   logic            in_valid;
   logic            in_ready;
   logic            in_rd_wen;
   logic [AW-1:0]   in_rd_addr;
   logic            in_src_mem;
   logic [XLEN-1:0] in_ex_res;
   logic [XLEN-1:0] in_mem_res;
   logic [2:0]      in_ext_mode;
   logic [XLEN-1:0] in_pc;
   logic            in_ebreak;

   modport master (
      output in_valid,
      output in_rd_wen,
      output in_rd_addr,
      output in_src_mem,
      output in_ex_res,
      output in_mem_res,
      output in_ext_mode,
      output in_pc,
      output in_ebreak,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_rd_wen,
      input  in_rd_addr,
      input  in_src_mem,
      input  in_ex_res,
      input  in_mem_res,
      input  in_ext_mode,
      input  in_pc,
      input  in_ebreak,
      output in_ready
   );
endinterface

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: extends and writes results, bypasses reads,
// publishes a registered commit record and halts on ebreak.
module wb_commit_unit #(
   parameter  int XLEN = 64,
   parameter  int NREG = 32,
   parameter  int NRD  = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   wb_commit_unit_if.slave   in_if,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic              commit_valid,
   output logic [XLEN-1:0]   commit_pc,
   output logic              commit_rd_wen,
   output logic [AW-1:0]     commit_rd_addr,
   output logic [XLEN-1:0]   commit_rd_data,
   output logic              halted,
   output logic [63:0]       instret
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HALT = 1'b1;

   logic [0:0]      state;
   logic [XLEN-1:0] regs [NREG];
   logic [XLEN-1:0] src;
   logic [XLEN-1:0] wd;
   logic            sgn;
   int              keep;
   logic            accept;
   logic            we;

   assign in_if.in_ready = (state == RUN);
   assign halted         = (state == HALT);
   assign accept         = in_if.in_valid & in_if.in_ready;

   assign we = accept & in_if.in_rd_wen
             & (in_if.in_rd_addr != '0)
             & (in_if.in_ext_mode != 3'd7);

   // Bits at or above 'keep' are replaced by the fill bit.
   always_comb begin
      src = in_if.in_src_mem ? in_if.in_mem_res
                             : in_if.in_ex_res;
      keep = XLEN;
      sgn  = 1'b0;
      case (in_if.in_ext_mode)
         3'd1: begin
            keep = 32;
            sgn  = src[31];
         end
         3'd2: keep = 32;
         3'd3: begin
            keep = 16;
            sgn  = src[15];
         end
         3'd4: keep = 16;
         3'd5: begin
            keep = 8;
            sgn  = src[7];
         end
         3'd6: keep = 8;
         default: keep = XLEN;
      endcase
      wd = src;
      for (int i = 0; i < XLEN; i++) begin
         if (i >= keep) wd[i] = sgn;
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[g*AW +: AW];
      assign rd_data[g*XLEN +: XLEN] =
         (ra == '0) ? '0 :
         (we && ra == in_if.in_rd_addr) ? wd :
         regs[ra];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we) begin
         regs[in_if.in_rd_addr] <= wd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= RUN;
         commit_valid   <= 1'b0;
         commit_pc      <= '0;
         commit_rd_wen  <= 1'b0;
         commit_rd_addr <= '0;
         commit_rd_data <= '0;
         instret        <= '0;
      end else begin
         commit_valid <= accept;
         if (accept) begin
            commit_pc      <= in_if.in_pc;
            commit_rd_wen  <= we;
            commit_rd_addr <= in_if.in_rd_addr;
            commit_rd_data <= we ? wd : '0;
            instret        <= instret + 64'd1;
            if (in_if.in_ebreak) state <= HALT;
         end
      end
   end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed + random bench for wb_commit_unit against an array model.
// A second XLEN=32 instance covers the narrow-datapath extension rules.
module tb_wb_commit_unit;
   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_commit_unit_if #(.XLEN(XLEN), .AW(AW)) bus ();
   wb_commit_unit_if #(.XLEN(32), .AW(AW)) bus32 ();

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic                commit_valid;
   logic [XLEN-1:0]     commit_pc;
   logic                commit_rd_wen;
   logic [AW-1:0]       commit_rd_addr;
   logic [XLEN-1:0]     commit_rd_data;
   logic                halted;
   logic [63:0]         instret;

   logic [NRD*AW-1:0] rd_addr32;
   logic [NRD*32-1:0] rd_data32;
   logic              commit_valid32;
   logic [31:0]       commit_pc32;
   logic              commit_rd_wen32;
   logic [AW-1:0]     commit_rd_addr32;
   logic [31:0]       commit_rd_data32;
   logic              halted32;
   logic [63:0]       instret32;

   wb_commit_unit #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_if          (bus.slave),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .commit_valid   (commit_valid),
      .commit_pc      (commit_pc),
      .commit_rd_wen  (commit_rd_wen),
      .commit_rd_addr (commit_rd_addr),
      .commit_rd_data (commit_rd_data),
      .halted         (halted),
      .instret        (instret)
   );

   wb_commit_unit #(.XLEN(32), .NREG(NREG), .NRD(NRD)) dut32 (
      .clk            (clk),
      .rst            (rst),
      .in_if          (bus32.slave),
      .rd_addr        (rd_addr32),
      .rd_data        (rd_data32),
      .commit_valid   (commit_valid32),
      .commit_pc      (commit_pc32),
      .commit_rd_wen  (commit_rd_wen32),
      .commit_rd_addr (commit_rd_addr32),
      .commit_rd_data (commit_rd_data32),
      .halted         (halted32),
      .instret        (instret32)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [63:0] mregs [NREG];
   logic [63:0] m_instret;
   bit          m_halted;
   bit          e_cv;
   logic [63:0] e_pc;
   bit          e_wen;
   logic [4:0]  e_addr;
   logic [63:0] e_data;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_ext(input logic [63:0] v,
                                           input logic [2:0] m);
      case (m)
         3'd1: return 64'($signed(v[31:0]));
         3'd2: return 64'(v[31:0]);
         3'd3: return 64'($signed(v[15:0]));
         3'd4: return 64'(v[15:0]);
         3'd5: return 64'($signed(v[7:0]));
         3'd6: return 64'(v[7:0]);
         default: return v;
      endcase
   endfunction

   function automatic bit cur_acc();
      return bus.in_valid && !m_halted && !rst;
   endfunction

   function automatic logic [63:0] cur_wd();
      return ref_ext(bus.in_src_mem ? bus.in_mem_res : bus.in_ex_res,
                     bus.in_ext_mode);
   endfunction

   function automatic bit cur_we();
      return cur_acc() && bus.in_rd_wen && bus.in_rd_addr != 0
             && bus.in_ext_mode != 3'd7;
   endfunction

   task automatic drive(input bit v, input bit wen, input logic [4:0] a,
                        input bit sm, input logic [63:0] ex,
                        input logic [63:0] mem, input logic [2:0] mode,
                        input logic [63:0] pc, input bit eb);
      bus.in_valid    = v;
      bus.in_rd_wen   = wen;
      bus.in_rd_addr  = a;
      bus.in_src_mem  = sm;
      bus.in_ex_res   = ex;
      bus.in_mem_res  = mem;
      bus.in_ext_mode = mode;
      bus.in_pc       = pc;
      bus.in_ebreak   = eb;
   endtask

   task automatic drive32(input bit v, input logic [4:0] a, input bit sm,
                          input logic [31:0] ex, input logic [31:0] mem,
                          input logic [2:0] mode);
      bus32.in_valid    = v;
      bus32.in_rd_wen   = 1'b1;
      bus32.in_rd_addr  = a;
      bus32.in_src_mem  = sm;
      bus32.in_ex_res   = ex;
      bus32.in_mem_res  = mem;
      bus32.in_ext_mode = mode;
      bus32.in_pc       = 32'h0;
      bus32.in_ebreak   = 1'b0;
   endtask

   task automatic chk_reads(input string tag);
      logic [4:0]  a;
      logic [63:0] e;
      #1;
      for (int p = 0; p < NRD; p++) begin
         a = rd_addr[p*AW +: AW];
         if (a == 0) e = 64'd0;
         else if (cur_we() && a == bus.in_rd_addr) e = cur_wd();
         else e = mregs[a];
         chk($sformatf("%s_rd%0d", tag, p), rd_data[p*XLEN +: XLEN], e);
      end
   endtask

   // Advance one edge, update the model, then check all registered outputs.
   task automatic tick(input string tag);
      bit          acc;
      bit          w;
      logic [63:0] d;
      acc = cur_acc();
      w   = cur_we();
      d   = cur_wd();
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < NREG; i++) mregs[i] = 64'd0;
         m_instret = 0;
         m_halted  = 0;
         e_cv = 0; e_pc = 0; e_wen = 0; e_addr = 0; e_data = 0;
      end else begin
         e_cv = acc;
         if (acc) begin
            if (w) mregs[bus.in_rd_addr] = d;
            m_instret = m_instret + 1;
            e_pc   = bus.in_pc;
            e_wen  = w;
            e_addr = bus.in_rd_addr;
            e_data = w ? d : 64'd0;
            if (bus.in_ebreak) m_halted = 1;
         end
      end
      chk({tag, "_cv"},    64'(commit_valid), 64'(e_cv));
      chk({tag, "_cpc"},   commit_pc, e_pc);
      chk({tag, "_cwen"},  64'(commit_rd_wen), 64'(e_wen));
      chk({tag, "_caddr"}, 64'(commit_rd_addr), 64'(e_addr));
      chk({tag, "_cdata"}, commit_rd_data, e_data);
      chk({tag, "_iret"},  instret, m_instret);
      chk({tag, "_halt"},  64'(halted), 64'(m_halted));
      chk({tag, "_rdy"},   64'(bus.in_ready), 64'(!m_halted));
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int pulses;
      rst = 1'b1;
      idle();
      drive32(0, 0, 0, 0, 0, 0);
      rd_addr   = '0;
      rd_addr32 = '0;
      tick("reset");
      rd_addr = {5'd9, 5'd5};
      chk_reads("reset");
      rst = 1'b0;

      // sext32 from MEM, narrow instance passes mode 1 unchanged
      drive(1, 1, 5, 1, 0, 64'h0000_0000_8000_0001, 1, 64'h100, 0);
      drive32(1, 5, 1, 0, 32'h8000_0001, 1);
      rd_addr = {5'd5, 5'd5};
      chk_reads("sext32_byp");
      tick("sext32");
      chk("sext32_cdata", commit_rd_data, 64'hFFFF_FFFF_8000_0001);
      chk("sext32_cwen", 64'(commit_rd_wen), 64'd1);
      chk("x32_mode1", 64'(commit_rd_data32), 64'h8000_0001);

      drive(1, 1, 6, 0, 64'h1234_5678_0000_00F0, 0, 5, 64'h104, 0);
      drive32(1, 6, 0, 32'h1234_00F0, 0, 5);
      chk_reads("sext8_byp");
      tick("sext8");
      chk("sext8_cdata", commit_rd_data, 64'hFFFF_FFFF_FFFF_FFF0);
      chk("x32_mode5", 64'(commit_rd_data32), 64'hFFFF_FFF0);

      drive(1, 1, 7, 0, 64'h1234_5678_0000_00F0, 0, 6, 64'h108, 0);
      drive32(1, 7, 0, 32'h1234_00F0, 0, 6);
      tick("zext8");
      chk("zext8_cdata", commit_rd_data, 64'h0000_0000_0000_00F0);
      chk("x32_mode6", 64'(commit_rd_data32), 64'h0000_00F0);
      drive32(0, 0, 0, 0, 0, 0);

      rd_addr = {5'd6, 5'd5};
      idle();
      chk_reads("regs_after");
      chk("reg5_val", rd_data[63:0], 64'hFFFF_FFFF_8000_0001);

      // x0 never stored
      drive(1, 1, 0, 0, 64'h1234, 0, 0, 64'h10C, 0);
      rd_addr = {5'd0, 5'd0};
      chk_reads("x0_byp");
      tick("x0");
      chk("x0_cwen", 64'(commit_rd_wen), 64'd0);
      idle();
      chk_reads("x0_after");
      chk("x0_read", rd_data[63:0], 64'd0);

      // mode 7 retires but does not write
      drive(1, 1, 3, 0, 64'h55, 0, 0, 64'h110, 0);
      tick("w3");
      drive(1, 1, 3, 0, 64'h99, 0, 7, 64'h114, 0);
      rd_addr = {5'd3, 5'd3};
      chk_reads("m7_byp");
      tick("m7");
      chk("m7_cv", 64'(commit_valid), 64'd1);
      idle();
      chk_reads("m7_after");
      chk("m7_reg3", rd_data[63:0], 64'h55);

      // same-cycle bypass on both ports
      drive(1, 1, 7, 0, 64'hAA, 0, 0, 64'h118, 0);
      rd_addr = {5'd7, 5'd7};
      chk_reads("byp");
      chk("byp_p0", rd_data[63:0], 64'hAA);
      chk("byp_p1", rd_data[127:64], 64'hAA);
      tick("byp");
      drive(0, 1, 7, 0, 64'hBB, 0, 0, 64'h11C, 0);
      chk_reads("nobyp");
      chk("nobyp_p0", rd_data[63:0], 64'hAA);
      chk("nobyp_p1", rd_data[127:64], 64'hAA);
      tick("nobyp");

      // reset dominates an accept
      drive(1, 1, 9, 0, 64'h77, 0, 0, 64'h120, 0);
      tick("w9");
      drive(1, 1, 9, 0, 64'h66, 0, 0, 64'h124, 0);
      rst = 1'b1;
      tick("rst_mid");
      rst = 1'b0;
      idle();
      rd_addr = {5'd7, 5'd9};
      chk_reads("rst_mid");
      chk("rst_reg9", rd_data[63:0], 64'd0);
      chk("rst_iret", instret, 64'd0);
      chk("rst_cv", 64'(commit_valid), 64'd0);
      drive(1, 1, 9, 0, 64'h42, 0, 0, 64'h128, 0);
      tick("resume");
      idle();
      chk_reads("resume");
      chk("resume_reg9", rd_data[63:0], 64'h42);

      // random traffic, no ebreak
      for (int k = 0; k < 300; k++) begin
         drive($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
               {$urandom, $urandom}, {$urandom, $urandom},
               3'($urandom_range(0, 7)), {$urandom, $urandom}, 0);
         rd_addr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
         if (k % 8 == 0) rd_addr = {bus.in_rd_addr, bus.in_rd_addr};
         chk_reads("rnd");
         tick("rnd");
      end

      // ebreak halt sequence
      rst = 1'b1;
      idle();
      tick("rst_eb");
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 5'(k + 1), 0, 64'(k + 10), 0, 0,
               64'h8000_0000 + 64'(4 * k), k == 2);
         tick("eb");
         if (commit_valid) pulses++;
      end
      chk("eb_pulses", 64'(pulses), 64'd3);
      chk("eb_iret", instret, 64'd3);
      chk("eb_halt", 64'(halted), 64'd1);
      chk("eb_rdy", 64'(bus.in_ready), 64'd0);
      chk("eb_cpc", commit_pc, 64'h8000_0008);
      for (int k = 0; k < 2; k++) begin
         drive(1, 1, 4, 0, 64'hDEAD, 0, 0, 64'h8000_000C, 0);
         rd_addr = {5'd3, 5'd4};
         chk_reads("halt_ign");
         tick("halt_ign");
      end
      chk("halt_reg4", rd_data[63:0], 64'd0);
      chk("halt_reg3", rd_data[127:64], 64'd12);

      rst = 1'b1;
      idle();
      tick("rst_end");
      rst = 1'b0;
      drive(1, 1, 2, 0, 64'h5, 0, 0, 64'h200, 0);
      tick("post_halt");
      chk("post_halt_iret", instret, 64'd1);
      idle();
      tick("tail");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
